hamming_ecc_unit: RTL and testbench

HAMMING_ECC_UNIT -- requirements
Module: hamming_ecc_unit

---
 rtl/hamming_ecc_unit.sv | 130 +++++++++++++
 tb/tb_hamming_ecc_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming_ecc_unit.sv
// SECDED Hamming(39,32) encoder and decoder/corrector with a one-cycle registered latency.
//
// The encoder and decoder paths are fully independent and both run every cycle.
// Codeword layout: code[0] is the overall parity bit. code[k], k = 1..38, is Hamming
// position k. Check bits sit at the power-of-two positions and data bits fill the
// remaining positions in ascending order.
//
// Ports:
//   clk       - clock; all outputs update on its rising edge
//   rst       - asynchronous active-high reset; clears every output immediately
//   data_in   - 32-bit raw data to encode
//   code_in   - 39-bit stored codeword to decode and correct
//   code_out  - registered encoding of data_in
//   data_out  - registered corrected data from code_in (raw extraction on d_err)
//   s_err     - registered flag: single-bit error detected and corrected
//   d_err     - registered flag: uncorrectable error detected
module hamming_ecc_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [38:0] code_in,
    output logic [38:0] code_out,
    output logic [31:0] data_out,
    output logic        s_err,
    output logic        d_err
);

    // Place data bits at the non-power-of-two Hamming positions; check and parity bits stay 0.
    function automatic logic [38:0] scatter(input logic [31:0] d);
        logic [38:0] c;
        c          = '0;
        c[3]       = d[0];
        c[7:5]     = d[3:1];
        c[15:9]    = d[10:4];
        c[31:17]   = d[25:11];
        c[38:33]   = d[31:26];
        return c;
    endfunction

    // Inverse of scatter: pull the data bits back out of a codeword.
    function automatic logic [31:0] gather(input logic [38:0] c);
        logic [31:0] d;
        d          = '0;
        d[0]       = c[3];
        d[3:1]     = c[7:5];
        d[10:4]    = c[15:9];
        d[25:11]   = c[31:17];
        d[31:26]   = c[38:33];
        return d;
    endfunction

    // Bit i is the XOR of every position 1..38 whose index has bit i set.
    function automatic logic [5:0] syndrome(input logic [38:0] c);
        logic [5:0] s;
        s = '0;
        for (int j = 1; j < 39; j++) begin
            for (int i = 0; i < 6; i++) begin
                if (j[i]) begin
                    s[i] = s[i] ^ c[j];
                end
            end
        end
        return s;
    endfunction

    logic [38:0] code_d;
    logic [31:0] data_d;
    logic        s_err_d;
    logic        d_err_d;

    // Encoder: with check bits still zero, the syndrome of the scattered data is exactly
    // the set of check-bit values that makes every parity group even.
    always_comb begin
        logic [38:0] c;
        logic [5:0]  chk;
        c       = scatter(data_in);
        chk     = syndrome(c);
        c[1]    = chk[0];
        c[2]    = chk[1];
        c[4]    = chk[2];
        c[8]    = chk[3];
        c[16]   = chk[4];
        c[32]   = chk[5];
        c[0]    = ^c[38:1];
        code_d  = c;
    end

    // Decoder: odd overall parity means an odd number of flips; a syndrome that points
    // inside the word is then a correctable single error. Anything else is uncorrectable
    // and the data is passed through uncorrected.
    always_comb begin
        logic [5:0]  syn;
        logic        par;
        logic [38:0] fixed;
        syn     = syndrome(code_in);
        par     = ^code_in;
        fixed   = code_in;
        s_err_d = 1'b0;
        d_err_d = 1'b0;
        if (par) begin
            if (syn == 6'd0) begin
                // Only the overall parity bit flipped; data is intact.
                s_err_d = 1'b1;
            end else if (syn <= 6'd38) begin
                fixed   = code_in ^ (39'd1 << syn);
                s_err_d = 1'b1;
            end else begin
                d_err_d = 1'b1;
            end
        end else if (syn != 6'd0) begin
            d_err_d = 1'b1;
        end
        data_d = gather(fixed);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_out <= '0;
            data_out <= '0;
            s_err    <= 1'b0;
            d_err    <= 1'b0;
        end else begin
            code_out <= code_d;
            data_out <= data_d;
            s_err    <= s_err_d;
            d_err    <= d_err_d;
        end
    end

endmodule

// File: tb/tb_hamming_ecc_unit.sv
// Self-checking bench for hamming_ecc_unit: scoreboard of expected outputs pushed at drive
// time and popped one clock later when the registered outputs are valid.
module tb_hamming_ecc_unit;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic [38:0] code_in;
    logic [38:0] code_out;
    logic [31:0] data_out;
    logic        s_err;
    logic        d_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [38:0] code;
        logic [31:0] data;
        logic        s;
        logic        d;
    } exp_t;

    exp_t sb[$];

    hamming_ecc_unit dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .code_in  (code_in),
        .code_out (code_out),
        .data_out (data_out),
        .s_err    (s_err),
        .d_err    (d_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference encoder: walk positions, assign data to non-powers of two, then derive
    // check bits as the XOR of the indices of all set data positions.
    function automatic logic [38:0] m_enc(input logic [31:0] d);
        logic [38:0] c;
        logic [5:0]  x;
        int          k;
        c = '0;
        k = 0;
        for (int j = 1; j < 39; j++) begin
            if ((j & (j - 1)) != 0) begin
                c[j] = d[k];
                k++;
            end
        end
        x = '0;
        for (int j = 1; j < 39; j++) if (c[j]) x = x ^ 6'(j);
        for (int i = 0; i < 6; i++) c[1 << i] = x[i];
        c[0] = ^c[38:1];
        return c;
    endfunction

    function automatic logic [31:0] m_ext(input logic [38:0] c);
        logic [31:0] d;
        int          k;
        d = '0;
        k = 0;
        for (int j = 1; j < 39; j++) begin
            if ((j & (j - 1)) != 0) begin
                d[k] = c[j];
                k++;
            end
        end
        return d;
    endfunction

    // Reference decoder producing the full expected tuple for a given code_in.
    function automatic exp_t m_dec(input logic [31:0] d, input logic [38:0] c);
        exp_t        e;
        logic [5:0]  x;
        logic        p;
        logic [38:0] f;
        x = '0;
        for (int j = 1; j < 39; j++) if (c[j]) x = x ^ 6'(j);
        p = ^c;
        f = c;
        e.s = 1'b0;
        e.d = 1'b0;
        if (p && x == 0) e.s = 1'b1;
        else if (p && x < 39) begin
            f[x] = ~f[x];
            e.s  = 1'b1;
        end else if (x != 0) e.d = 1'b1;
        e.data = m_ext(f);
        e.code = m_enc(d);
        return e;
    endfunction

    task automatic drive(input string tag, input logic [31:0] d, input logic [38:0] c,
                         input exp_t e);
        exp_t r;
        @(negedge clk);
        data_in = d;
        code_in = c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            r = sb.pop_front();
            check_eq({tag, "_code"}, 64'(code_out), 64'(r.code));
            check_eq({tag, "_data"}, 64'(data_out), 64'(r.data));
            check_eq({tag, "_s"},    64'(s_err),    64'(r.s));
            check_eq({tag, "_d"},    64'(d_err),    64'(r.d));
        end
    endtask

    function automatic exp_t mk(input logic [38:0] c, input logic [31:0] d, input logic s,
                                input logic dd);
        exp_t e;
        e.code = c;
        e.data = d;
        e.s    = s;
        e.d    = dd;
        return e;
    endfunction

    task automatic check_zero(input string tag);
        check_eq({tag, "_code"}, 64'(code_out), 64'd0);
        check_eq({tag, "_data"}, 64'(data_out), 64'd0);
        check_eq({tag, "_s"},    64'(s_err),    64'd0);
        check_eq({tag, "_d"},    64'(d_err),    64'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [38:0] enc;
        logic [38:0] one;
        int          b1;
        int          b2;
        one     = 39'd1;
        rst     = 1'b1;
        data_in = 32'h0;
        code_in = 39'h0;
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-derived expectations.
        drive("enc1",   32'h00000001, 39'h000000000F,
              mk(39'h000000000F, 32'h00000001, 1'b0, 1'b0));
        drive("enctop", 32'h80000000, 39'h0000000007,
              mk(39'h4100000014, 32'h00000001, 1'b1, 1'b0));
        drive("enc0",   32'h00000000, 39'h000000000E,
              mk(39'h0000000000, 32'h00000001, 1'b1, 1'b0));
        drive("dbl",    32'h00000000, 39'h000000000C,
              mk(39'h0000000000, 32'h00000001, 1'b0, 1'b1));
        drive("s39",    32'h00000000, 39'h0100000081,
              mk(39'h0000000000, 32'h00000008, 1'b0, 1'b1));

        // Asynchronous reset between edges with non-zero outputs pending.
        drive("pre_rst", 32'hFFFFFFFF, 39'h000000000F,
              mk(m_enc(32'hFFFFFFFF), 32'h00000001, 1'b0, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        check_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        drive("post_rst", 32'h00000001, 39'h0000000007,
              mk(39'h000000000F, 32'h00000001, 1'b1, 1'b0));

        // Every single-bit flip of a random codeword corrects back to the original data.
        for (int t = 0; t < 4; t++) begin
            rd  = $urandom();
            enc = m_enc(rd);
            drive("clean", rd, enc, mk(enc, rd, 1'b0, 1'b0));
            for (int b = 0; b < 39; b++) begin
                drive("single", rd, enc ^ (one << b), mk(enc, rd, 1'b1, 1'b0));
            end
        end

        // Random double flips are always flagged uncorrectable.
        for (int t = 0; t < 40; t++) begin
            rd  = $urandom();
            enc = m_enc(rd);
            b1  = $urandom_range(38, 0);
            b2  = $urandom_range(37, 0);
            if (b2 >= b1) b2++;
            drive("double", rd, enc ^ (one << b1) ^ (one << b2),
                  mk(enc, m_ext(enc ^ (one << b1) ^ (one << b2)), 1'b0, 1'b1));
        end

        // Independent random traffic on both paths against the reference model.
        for (int t = 0; t < 40; t++) begin
            rd  = $urandom();
            enc = {7'($urandom()), 32'($urandom())};
            drive("rand", rd, enc, m_dec(rd, enc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
